// File: rtl/pll_lock_supervisor_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor.
//   pll_state_e  : supervisor state encoding (values 0..4 are externally visible
//                  on state_o, so they are fixed)
//   RETRY_W      : width of the failed-attempt counter
//   LOSS_W       : width of the saturating lock-loss counter
//   cnt_width()  : timer width needed to hold values up to a given count
// -----------------------------------------------------------------------------
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  // Largest of four timing parameters; sizes the shared timer.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Timer compares against (param-1), so clog2(param) bits are sufficient.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for slow, level-type asynchronous signals.
// Ports:
//   clk    in        destination clock
//   rst_n  in        asynchronous active-low reset, forces both stages to RESET_VAL
//   d      in  [W]   asynchronous input
//   q      out [W]   synchronized output (2 clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences the rPLL: pulses its RESET, waits for LOCK, requires LOCK to stay
// continuously high before releasing the downstream reset, and re-sequences on
// lock loss. Repeated failed lock attempts latch FAULT until retry_req.
// Runs on the PLL reference clock so it keeps working while the PLL is down.
// Ports:
//   clkin       in      reference clock (same net as rPLL CLKIN)
//   rst_n       in      asynchronous active-low reset
//   pll_lock_i  in      rPLL LOCK, asynchronous to clkin
//   retry_req   in      one-cycle pulse, leaves FAULT (ignored elsewhere)
//   pll_reset   out     rPLL RESET, active high
//   sys_rst_n   out     downstream reset, released only in RUN
//   locked      out     high only in RUN
//   fault       out     high only in FAULT
//   state_o     out [3] current state encoding
//   retry_cnt   out [4] failed attempts since last successful lock
//   loss_cnt    out [8] lock losses seen in RUN, saturating
// -----------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic               pll_lock_i,
  input  logic               retry_req,
  output logic               pll_reset,
  output logic               sys_rst_n,
  output logic               locked,
  output logic               fault,
  output logic [2:0]         state_o,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  localparam int CNT_MAX = max4(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, 2);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  pll_state_e         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic [LOSS_W-1:0]  loss_reg, loss_next;
  logic [RETRY_W-1:0] retry_inc;

  logic pll_reset_reg, sys_rst_n_reg, locked_reg, fault_reg;

  // LOCK comes from the PLL's own analog domain; only the synchronized copy
  // is allowed into the FSM.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  assign retry_inc = retry_reg + RETRY_W'(1);

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    loss_next  = loss_reg;
    case (state_reg)
      ST_RESET_PLL: begin
        if (cnt_reg == RST_LAST) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_next = ST_STABLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          retry_next = retry_inc;
          state_next = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
        end
      end
      ST_STABLE: begin
        // A drop on the final cycle still aborts; a flicker is not a failed attempt.
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = ST_RUN;
          retry_next = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_next = ST_RESET_PLL;
          if (loss_reg != LOSS_MAX) loss_next = loss_reg + LOSS_W'(1);
        end
      end
      ST_FAULT: begin
        if (retry_req) begin
          state_next = ST_RESET_PLL;
          retry_next = '0;
        end
      end
      default: state_next = ST_RESET_PLL;
    endcase
  end

  // One timer serves every state: it restarts on each transition.
  assign cnt_next = (state_next != state_reg) ? '0 : cnt_reg + CNT_W'(1);

  // Outputs are decoded from state_next and registered, so they switch on
  // the same edge as state_o and never see a combinational input path.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RESET_PLL;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      loss_reg      <= '0;
      pll_reset_reg <= 1'b1;
      sys_rst_n_reg <= 1'b0;
      locked_reg    <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      loss_reg      <= loss_next;
      pll_reset_reg <= (state_next == ST_RESET_PLL) || (state_next == ST_FAULT);
      sys_rst_n_reg <= (state_next == ST_RUN);
      locked_reg    <= (state_next == ST_RUN);
      fault_reg     <= (state_next == ST_FAULT);
    end
  end

  assign state_o   = state_reg;
  assign retry_cnt = retry_reg;
  assign loss_cnt  = loss_reg;
  assign pll_reset = pll_reset_reg;
  assign sys_rst_n = sys_rst_n_reg;
  assign locked    = locked_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed scenarios with hand-computed edge expectations, a saturation loop
// with random timing, and a random lock/retry soak, all compared each cycle
// against a dwell-time model of the supervisor.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int RST  = 4;
  localparam int TO   = 20;
  localparam int STB  = 8;
  localparam int MAXR = 3;

  logic       clkin      = 1'b0;
  logic       rst_n      = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       retry_req  = 1'b0;
  logic       pll_reset, sys_rst_n, locked, fault;
  logic [2:0] state_o;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int total  = 0;
  int passed = 0;

  always #5 clkin = ~clkin;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (STB),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .pll_lock_i (pll_lock_i),
    .retry_req  (retry_req),
    .pll_reset  (pll_reset),
    .sys_rst_n  (sys_rst_n),
    .locked     (locked),
    .fault      (fault),
    .state_o    (state_o),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  // ---------------- reference model ----------------
  // n: edges since reset release. m_enter: edge at which the current phase
  // began. A phase with dwell D is left at edge m_enter + D.
  // lock_seen[1] is pll_lock_i as sampled two edges ago.
  int n       = 0;
  int m_phase = 0;
  int m_enter = 0;
  int m_retry = 0;
  int m_loss  = 0;
  bit lock_seen [2];
  bit armed   = 1'b0;

  task automatic go(input int p);
    m_phase = p;
    m_enter = n;
    $display("txn edge %0d: phase -> %0d retry=%0d loss=%0d", n, p, m_retry, m_loss);
  endtask

  always @(posedge clkin) begin
    bit lk;
    int dwell;
    logic [2:0] e_state;
    logic       e_pr, e_run, e_fault;
    if (!rst_n) begin
      n = 0; m_phase = 0; m_enter = 0; m_retry = 0; m_loss = 0;
      lock_seen[0] = 1'b0; lock_seen[1] = 1'b0;
    end else begin
      n++;
      lk = lock_seen[1];
      lock_seen[1] = lock_seen[0];
      lock_seen[0] = pll_lock_i;
      dwell = n - m_enter;
      case (m_phase)
        0: if (dwell == RST) go(1);
        1: if (lk) go(2);
           else if (dwell == TO) begin
             m_retry++;
             go((m_retry == MAXR) ? 4 : 0);
           end
        2: if (!lk) go(1);
           else if (dwell == STB) begin m_retry = 0; go(3); end
        3: if (!lk) begin
             if (m_loss < 255) m_loss++;
             go(0);
           end
        default: if (retry_req) begin m_retry = 0; go(0); end
      endcase
    end
    #1;
    if (armed) begin
      e_state = 3'(m_phase);
      e_pr    = (m_phase == 0) || (m_phase == 4);
      e_run   = (m_phase == 3);
      e_fault = (m_phase == 4);
      total++;
      if ({state_o, pll_reset, sys_rst_n, locked, fault, retry_cnt, loss_cnt} ===
          {e_state, e_pr, e_run, e_run, e_fault, 4'(m_retry), 8'(m_loss)})
        passed++;
      else
        $display("FAIL model_cmp edge %0d: got st=%0d pr=%0b srn=%0b lk=%0b f=%0b r=%0d l=%0d, want st=%0d pr=%0b srn=%0b lk=%0b f=%0b r=%0d l=%0d",
                 n, state_o, pll_reset, sys_rst_n, locked, fault, retry_cnt, loss_cnt,
                 e_state, e_pr, e_run, e_run, e_fault, m_retry, m_loss);
    end
  end

  // ---------------- helpers ----------------
  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic after_edge(input int k);
    int g = 0;
    while (n < k) begin
      @(posedge clkin); #1;
      g++;
      if (g > 3000) begin
        total++;
        $display("FAIL after_edge_timeout: reached edge %0d, wanted %0d", n, k);
        return;
      end
    end
  endtask

  task automatic wait_phase(input int p);
    int g = 0;
    while (m_phase != p) begin
      @(posedge clkin); #1;
      g++;
      if (g > 3000) begin
        total++;
        $display("FAIL wait_phase_timeout: phase %0d, wanted %0d", m_phase, p);
        return;
      end
    end
  endtask

  // Asserts rst_n mid-cycle, checks reset values immediately, then releases
  // on a falling edge so the next rising edge is edge 1.
  task automatic do_reset(input logic lock_val);
    @(negedge clkin); #2;
    rst_n = 1'b0;
    #1;
    check_lit("rst_state",     state_o,   0);
    check_lit("rst_pll_reset", pll_reset, 1);
    check_lit("rst_sys_rst_n", sys_rst_n, 0);
    check_lit("rst_locked",    locked,    0);
    check_lit("rst_fault",     fault,     0);
    check_lit("rst_retry",     retry_cnt, 0);
    check_lit("rst_loss",      loss_cnt,  0);
    armed      = 1'b1;
    pll_lock_i = lock_val;
    retry_req  = 1'b0;
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;
    $display("txn reset released, lock=%0b", lock_val);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Clean start
    do_reset(1'b1);
    after_edge(3);  check_lit("clean_pll_reset_e3", pll_reset, 1);
    after_edge(4);  check_lit("clean_pll_reset_e4", pll_reset, 0);
    after_edge(12); check_lit("clean_sys_rst_e12",  sys_rst_n, 0);
    after_edge(13); check_lit("clean_sys_rst_e13",  sys_rst_n, 1);
                    check_lit("clean_locked_e13",   locked,    1);
                    check_lit("clean_retry_e13",    retry_cnt, 0);

    // Lock loss in RUN, drop before edge 30
    after_edge(29); @(negedge clkin) pll_lock_i = 1'b0;
    after_edge(31); check_lit("loss_sys_rst_e31", sys_rst_n, 1);
    after_edge(32); check_lit("loss_sys_rst_e32", sys_rst_n, 0);
                    check_lit("loss_pll_rst_e32", pll_reset, 1);
                    check_lit("loss_cnt_e32",     loss_cnt,  1);
    @(negedge clkin) pll_lock_i = 1'b1;
    after_edge(44); check_lit("relock_e44", locked, 0);
    after_edge(45); check_lit("relock_e45", locked, 1);

    // Saturate loss_cnt with random drop timing
    for (int i = 0; i < 256; i++) begin
      wait_phase(3);
      repeat ($urandom_range(0, 3)) @(negedge clkin);
      @(negedge clkin) pll_lock_i = 1'b0;
      wait_phase(0);
      repeat ($urandom_range(0, 3)) @(negedge clkin);
      @(negedge clkin) pll_lock_i = 1'b1;
    end
    wait_phase(3);
    check_lit("loss_saturated", loss_cnt, 255);

    // Reset in RUN, then lock never arrives
    do_reset(1'b0);
    after_edge(23); check_lit("to_state_e23", state_o,   1);
    after_edge(24); check_lit("to_retry_e24", retry_cnt, 1);
                    check_lit("to_state_e24", state_o,   0);
    after_edge(48); check_lit("to_retry_e48", retry_cnt, 2);
    after_edge(71); check_lit("to_fault_e71", fault,     0);
    after_edge(72); check_lit("to_fault_e72", fault,     1);
                    check_lit("to_pllrst_e72", pll_reset, 1);
                    check_lit("to_retry_e72", retry_cnt, 3);
                    check_lit("to_state_e72", state_o,   4);
    after_edge(79);
    @(negedge clkin) retry_req = 1'b1;
    @(negedge clkin) retry_req = 1'b0;
    after_edge(80); check_lit("retry_state_e80", state_o,   0);
                    check_lit("retry_cnt_e80",   retry_cnt, 0);
                    check_lit("retry_fault_e80", fault,     0);

    // Flicker in STABLE after one failed attempt
    do_reset(1'b0);
    after_edge(29); @(negedge clkin) pll_lock_i = 1'b1;
    after_edge(32); check_lit("flk_state_e32", state_o,   2);
                    check_lit("flk_retry_e32", retry_cnt, 1);
    after_edge(34); @(negedge clkin) pll_lock_i = 1'b0;
    after_edge(36); check_lit("flk_state_e36", state_o,   2);
    after_edge(37); check_lit("flk_state_e37", state_o,   1);
                    check_lit("flk_retry_e37", retry_cnt, 1);
    @(negedge clkin) pll_lock_i = 1'b1;
    after_edge(39); check_lit("flk_state_e39", state_o,   1);
    after_edge(40); check_lit("flk_state_e40", state_o,   2);
    after_edge(47); check_lit("flk_locked_e47", locked,   0);
    after_edge(48); check_lit("flk_locked_e48", locked,   1);
                    check_lit("flk_retry_e48", retry_cnt, 0);

    // Lock arriving on the timeout cycle of the second attempt
    do_reset(1'b0);
    after_edge(45); @(negedge clkin) pll_lock_i = 1'b1;
    after_edge(47); check_lit("tie_state_e47", state_o,   1);
    after_edge(48); check_lit("tie_state_e48", state_o,   2);
                    check_lit("tie_retry_e48", retry_cnt, 1);
    after_edge(56); check_lit("tie_state_e56", state_o,   3);
    after_edge(57);
    @(negedge clkin) retry_req = 1'b1;
    @(negedge clkin) retry_req = 1'b0;
    after_edge(58); check_lit("run_retry_ignored", state_o, 3);
                    check_lit("run_locked_e58",    locked,  1);

    // Reset asserted in STABLE, restart from edge 1
    do_reset(1'b1);
    after_edge(8);  check_lit("stb_state_e8", state_o, 2);
    do_reset(1'b1);
    after_edge(12); check_lit("restart_locked_e12", locked, 0);
    after_edge(13); check_lit("restart_locked_e13", locked, 1);

    // Random soak
    for (int c = 0; c < 800; c++) begin
      @(negedge clkin);
      if ($urandom_range(0, 9) == 0) pll_lock_i = ~pll_lock_i;
      retry_req = ($urandom_range(0, 15) == 0);
    end
    @(negedge clkin) retry_req = 1'b0;
    repeat (3) @(negedge clkin);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
